// File: rtl/vend_ctrl_multi.sv
`default_nettype none
// ============================================================================
// Module   : vend_ctrl_multi
// Purpose  : Parametrised vending-machine controller. N products with a
//            runtime price table, capped credit register, cancel/refund,
//            and coin-by-coin change return over a valid/ready handshake.
//            Credit and change are also presented as 3-digit BCD for the
//            seven-segment display driver.
// Optional : define VEND_TIMEOUT_EN to add a 26-bit inactivity counter that
//            auto-refunds credit after TIMEOUT_CYCLES idle cycles in CREDIT.
// Ports    :
//   clk50, reset_n        clock (rising edge), async active-low reset
//   coin[2:0]             coin strobe: 1=5c 2=10c 3=25c 4=100c, 5-7 invalid
//   productSelect/select_valid  product index and its one-cycle qualifier
//   cancel                one-cycle refund request
//   price_table           flat prices, product k at [k*PW +: PW]
//   change_ready          hopper accepts the presented change coin
//   dispense/dispense_id  vend pulse and held product index
//   coin_reject/insufficient/sel_error  one-cycle status pulses
//   change_valid/change_coin  presented change coin (1=25c 2=10c 3=5c)
//   moneyBCD/changeBCD    credit and remaining change as BCD
//   busy                  high while dispensing or returning change
// Revision : 1.0  initial release
// ============================================================================
module vend_ctrl_multi #(
  parameter int NUM_PRODUCTS   = 8,
  parameter int MAX_CREDIT     = 500,
  parameter int PW             = 10,
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int SW             = (NUM_PRODUCTS > 1) ? $clog2(NUM_PRODUCTS) : 1
) (
  input  logic                     clk50,
  input  logic                     reset_n,
  input  logic [2:0]               coin,
  input  logic [SW-1:0]            productSelect,
  input  logic                     select_valid,
  input  logic                     cancel,
  input  logic [NUM_PRODUCTS*PW-1:0] price_table,
  input  logic                     change_ready,
  output logic                     dispense,
  output logic [SW-1:0]            dispense_id,
  output logic                     coin_reject,
  output logic                     insufficient,
  output logic                     sel_error,
  output logic                     change_valid,
  output logic [1:0]               change_coin,
  output logic [11:0]              moneyBCD,
  output logic [11:0]              changeBCD,
  output logic                     busy
);

  if ((MAX_CREDIT % 5) != 0 || MAX_CREDIT > 999 || TIMEOUT_CYCLES < 1 ||
      TIMEOUT_CYCLES > (1 << 26)) begin : g_bad_params
    $error("vend_ctrl_multi: invalid parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CREDIT   = 2'd1,
    S_DISPENSE = 2'd2,
    S_CHANGE   = 2'd3
  } state_t;

  state_t          state, state_d;
  logic [PW-1:0]   credit, credit_d;
  logic [PW-1:0]   change, change_d;
  logic [SW-1:0]   id_d;
  logic            reject_d, insuf_d, selerr_d;

  logic [PW-1:0]   coin_val;
  logic            coin_ok;
  logic [PW:0]     credit_sum;
  logic            cap_ok;
  logic [PW-1:0]   price_sel;
  logic            sel_in_range;
  logic [1:0]      greedy_code;
  logic [PW-1:0]   greedy_val;
  logic            auto_cancel;

  // Coin decode
  always_comb begin
    coin_val = '0;
    coin_ok  = 1'b1;
    case (coin)
      3'd1:    coin_val = PW'(5);
      3'd2:    coin_val = PW'(10);
      3'd3:    coin_val = PW'(25);
      3'd4:    coin_val = PW'(100);
      default: coin_ok  = 1'b0;
    endcase
  end

  // One extra bit so the cap comparison sees the true sum
  assign credit_sum = {1'b0, credit} + {1'b0, coin_val};
  assign cap_ok     = credit_sum <= (PW+1)'(MAX_CREDIT);

  // Price lookup; out-of-range indices read as zero and are flagged separately
  assign sel_in_range = 32'(productSelect) < NUM_PRODUCTS;
  always_comb begin
    price_sel = '0;
    for (int k = 0; k < NUM_PRODUCTS; k++) begin
      if (productSelect == SW'(k)) price_sel = price_table[k*PW +: PW];
    end
  end

  // Greedy change coin for the remaining amount
  always_comb begin
    if (change >= PW'(25)) begin
      greedy_code = 2'd1;
      greedy_val  = PW'(25);
    end else if (change >= PW'(10)) begin
      greedy_code = 2'd2;
      greedy_val  = PW'(10);
    end else begin
      greedy_code = 2'd3;
      greedy_val  = PW'(5);
    end
  end

`ifdef VEND_TIMEOUT_EN
  logic [25:0] idle_cnt;
  logic        strobe_any;

  assign strobe_any  = (coin != 3'd0) | select_valid | cancel;
  assign auto_cancel = (state == S_CREDIT) && !strobe_any &&
                       (idle_cnt == 26'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt <= '0;
    end else if ((state == S_CREDIT) && !strobe_any && !auto_cancel) begin
      idle_cnt <= idle_cnt + 26'd1;
    end else begin
      idle_cnt <= '0;
    end
  end
`else
  assign auto_cancel = 1'b0;
`endif

  // Next-state logic: cancel > select > coin
  always_comb begin
    state_d  = state;
    credit_d = credit;
    change_d = change;
    id_d     = dispense_id;
    reject_d = 1'b0;
    insuf_d  = 1'b0;
    selerr_d = 1'b0;
    case (state)
      S_IDLE, S_CREDIT: begin
        if (cancel || auto_cancel) begin
          reject_d = (coin != 3'd0);
          if (state == S_CREDIT) begin
            change_d = credit;
            credit_d = '0;
            state_d  = S_CHANGE;
          end
        end else if (select_valid) begin
          reject_d = (coin != 3'd0);
          if (!sel_in_range) begin
            selerr_d = 1'b1;
          end else if (credit < price_sel) begin
            insuf_d = 1'b1;
          end else begin
            change_d = credit - price_sel;
            credit_d = '0;
            id_d     = productSelect;
            state_d  = S_DISPENSE;
          end
        end else if (coin != 3'd0) begin
          if (coin_ok && cap_ok) begin
            credit_d = credit_sum[PW-1:0];
            state_d  = S_CREDIT;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      S_DISPENSE: begin
        reject_d = (coin != 3'd0);
        state_d  = (change != '0) ? S_CHANGE : S_IDLE;
      end
      S_CHANGE: begin
        reject_d = (coin != 3'd0);
        if (change_ready) begin
          // Saturate so a price that is not a multiple of 5 cannot underflow
          if (change <= greedy_val) begin
            change_d = '0;
            state_d  = S_IDLE;
          end else begin
            change_d = change - greedy_val;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      credit       <= '0;
      change       <= '0;
      dispense_id  <= '0;
      coin_reject  <= 1'b0;
      insufficient <= 1'b0;
      sel_error    <= 1'b0;
    end else begin
      state        <= state_d;
      credit       <= credit_d;
      change       <= change_d;
      dispense_id  <= id_d;
      coin_reject  <= reject_d;
      insufficient <= insuf_d;
      sel_error    <= selerr_d;
    end
  end

  assign dispense     = (state == S_DISPENSE);
  assign change_valid = (state == S_CHANGE);
  assign change_coin  = change_valid ? greedy_code : 2'd0;
  assign busy         = (state == S_DISPENSE) || (state == S_CHANGE);

  // Double-dabble binary to 3-digit BCD
  function automatic logic [11:0] to_bcd(input logic [PW-1:0] bin);
    logic [11:0] bcd;
    bcd = '0;
    for (int i = PW - 1; i >= 0; i--) begin
      if (bcd[3:0]  > 4'd4) bcd[3:0]  = bcd[3:0]  + 4'd3;
      if (bcd[7:4]  > 4'd4) bcd[7:4]  = bcd[7:4]  + 4'd3;
      if (bcd[11:8] > 4'd4) bcd[11:8] = bcd[11:8] + 4'd3;
      bcd = {bcd[10:0], bin[i]};
    end
    return bcd;
  endfunction

  assign moneyBCD  = to_bcd(credit);
  assign changeBCD = to_bcd(change);

endmodule
`default_nettype wire

// File: tb/tb_vend_ctrl_multi.sv
`default_nettype none
module tb_vend_ctrl_multi;
  localparam int N    = 6;
  localparam int PW   = 10;
  localparam int MAXC = 500;
  localparam int TMO  = 100;
  localparam int SW   = 3;

  logic            clk50 = 1'b0;
  logic            reset_n = 1'b0;
  logic [2:0]      coin = '0;
  logic [SW-1:0]   productSelect = '0;
  logic            select_valid = 1'b0;
  logic            cancel = 1'b0;
  logic [N*PW-1:0] price_table = '0;
  logic            change_ready = 1'b0;
  logic            dispense;
  logic [SW-1:0]   dispense_id;
  logic            coin_reject, insufficient, sel_error, change_valid, busy;
  logic [1:0]      change_coin;
  logic [11:0]     moneyBCD, changeBCD;

  vend_ctrl_multi #(.NUM_PRODUCTS(N), .MAX_CREDIT(MAXC), .PW(PW),
                    .TIMEOUT_CYCLES(TMO)) dut (
    .clk50(clk50), .reset_n(reset_n), .coin(coin),
    .productSelect(productSelect), .select_valid(select_valid),
    .cancel(cancel), .price_table(price_table), .change_ready(change_ready),
    .dispense(dispense), .dispense_id(dispense_id), .coin_reject(coin_reject),
    .insufficient(insufficient), .sel_error(sel_error),
    .change_valid(change_valid), .change_coin(change_coin),
    .moneyBCD(moneyBCD), .changeBCD(changeBCD), .busy(busy)
  );

  always #5 clk50 = ~clk50;

  int n_tests = 0;
  int n_fail  = 0;
  int prices[N];

  // Output bundle: money, change, dispense, id, valid, coin, reject, insuf, selerr, busy
  typedef logic [34:0] obs_t;

  function automatic obs_t mk(input logic [11:0] money, input logic [11:0] chg,
                              input logic disp, input logic [2:0] id,
                              input logic valid, input logic [1:0] cc,
                              input logic rej, input logic ins,
                              input logic serr, input logic bsy);
    return {money, chg, disp, id, valid, cc, rej, ins, serr, bsy};
  endfunction

  function automatic obs_t actual();
    return {moneyBCD, changeBCD, dispense, dispense_id, change_valid,
            change_coin, coin_reject, insufficient, sel_error, busy};
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk50);
    #1;
  endtask

  task automatic clear_strobes();
    coin = '0;
    select_valid = 1'b0;
    cancel = 1'b0;
  endtask

  task automatic load_prices();
    for (int k = 0; k < N; k++) price_table[k*PW +: PW] = PW'(prices[k]);
  endtask

  task automatic put_coin(input logic [2:0] c);
    coin = c;
    tick();
    clear_strobes();
  endtask

  // ---------------- reference model ----------------
  int  m_credit;
  int  m_q[$];          // change coins still owed, in return order
  bit  m_vend;
  int  m_id;
  bit  m_rej, m_ins, m_serr;
  int  m_idle;

  function automatic logic [11:0] bcd(input int v);
    return 12'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
  endfunction

  function automatic int qsum();
    int s = 0;
    foreach (m_q[i]) s += m_q[i];
    return s;
  endfunction

  task automatic make_change(input int amt);
    int a = amt;
    m_q.delete();
    while (a >= 25) begin m_q.push_back(25); a -= 25; end
    while (a >= 10) begin m_q.push_back(10); a -= 10; end
    while (a >= 5)  begin m_q.push_back(5);  a -= 5;  end
  endtask

  task automatic model_reset();
    m_credit = 0; m_q.delete(); m_vend = 0; m_id = 0;
    m_rej = 0; m_ins = 0; m_serr = 0; m_idle = 0;
  endtask

  task automatic model_step();
    int  v;
    bit  strobe, idle_phase, auto_c;
    v = (coin == 3'd1) ? 5 : (coin == 3'd2) ? 10 : (coin == 3'd3) ? 25 :
        (coin == 3'd4) ? 100 : 0;
    strobe = (coin != 0) || select_valid || cancel;
    idle_phase = !m_vend && (m_q.size() == 0) && (m_credit > 0);
    auto_c = 0;
`ifdef VEND_TIMEOUT_EN
    auto_c = idle_phase && !strobe && (m_idle == TMO - 1);
    m_idle = (idle_phase && !strobe && !auto_c) ? m_idle + 1 : 0;
`endif
    m_rej = 0; m_ins = 0; m_serr = 0;
    if (m_vend) begin
      m_vend = 0;
      m_rej = (coin != 0);
    end else if (m_q.size() > 0) begin
      m_rej = (coin != 0);
      if (change_ready) void'(m_q.pop_front());
    end else if (cancel || auto_c) begin
      m_rej = (coin != 0);
      if (m_credit > 0) begin make_change(m_credit); m_credit = 0; end
    end else if (select_valid) begin
      m_rej = (coin != 0);
      if (int'(productSelect) >= N) m_serr = 1;
      else if (m_credit < prices[productSelect]) m_ins = 1;
      else begin
        make_change(m_credit - prices[productSelect]);
        m_credit = 0; m_vend = 1; m_id = int'(productSelect);
      end
    end else if (coin != 0) begin
      if (v == 0 || m_credit + v > MAXC) m_rej = 1;
      else m_credit += v;
    end
  endtask

  function automatic obs_t expected();
    bit   valid;
    logic [1:0] cc;
    valid = !m_vend && (m_q.size() > 0);
    cc = !valid ? 2'd0 : (m_q[0] == 25) ? 2'd1 : (m_q[0] == 10) ? 2'd2 : 2'd3;
    return mk(bcd(m_credit), bcd(qsum()), m_vend, 3'(m_id), valid, cc,
              m_rej, m_ins, m_serr, m_vend || (m_q.size() > 0));
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [2:0]    coin;
    logic          sel;
    logic [SW-1:0] idx;
    logic          cncl;
    logic          rdy;
    obs_t          exp;
  } tv_t;

  tv_t vecs[16];

  initial begin
    vecs[0]  = '{3'd3, 1'b0, 3'd0, 1'b0, 1'b0, mk(12'h025, 12'h000, 0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[1]  = '{3'd3, 1'b0, 3'd0, 1'b0, 1'b0, mk(12'h050, 12'h000, 0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[2]  = '{3'd2, 1'b0, 3'd0, 1'b0, 1'b0, mk(12'h060, 12'h000, 0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[3]  = '{3'd0, 1'b0, 3'd0, 1'b0, 1'b0, mk(12'h060, 12'h000, 0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[4]  = '{3'd0, 1'b1, 3'd2, 1'b0, 1'b1, mk(12'h000, 12'h015, 1, 2, 0, 0, 0, 0, 0, 1)};
    vecs[5]  = '{3'd0, 1'b0, 3'd0, 1'b0, 1'b1, mk(12'h000, 12'h015, 0, 2, 1, 2, 0, 0, 0, 1)};
    vecs[6]  = '{3'd0, 1'b0, 3'd0, 1'b0, 1'b1, mk(12'h000, 12'h005, 0, 2, 1, 3, 0, 0, 0, 1)};
    vecs[7]  = '{3'd0, 1'b0, 3'd0, 1'b0, 1'b1, mk(12'h000, 12'h000, 0, 2, 0, 0, 0, 0, 0, 0)};
    vecs[8]  = '{3'd0, 1'b1, 3'd7, 1'b0, 1'b0, mk(12'h000, 12'h000, 0, 2, 0, 0, 0, 0, 1, 0)};
    vecs[9]  = '{3'd2, 1'b0, 3'd0, 1'b0, 1'b0, mk(12'h010, 12'h000, 0, 2, 0, 0, 0, 0, 0, 0)};
    vecs[10] = '{3'd2, 1'b0, 3'd0, 1'b0, 1'b0, mk(12'h020, 12'h000, 0, 2, 0, 0, 0, 0, 0, 0)};
    vecs[11] = '{3'd0, 1'b1, 3'd0, 1'b0, 1'b0, mk(12'h020, 12'h000, 0, 2, 0, 0, 0, 1, 0, 0)};
    vecs[12] = '{3'd0, 1'b0, 3'd0, 1'b1, 1'b0, mk(12'h000, 12'h020, 0, 2, 1, 2, 0, 0, 0, 1)};
    vecs[13] = '{3'd0, 1'b0, 3'd0, 1'b0, 1'b1, mk(12'h000, 12'h010, 0, 2, 1, 2, 0, 0, 0, 1)};
    vecs[14] = '{3'd0, 1'b0, 3'd0, 1'b0, 1'b1, mk(12'h000, 12'h000, 0, 2, 0, 0, 0, 0, 0, 0)};
    vecs[15] = '{3'd5, 1'b0, 3'd0, 1'b0, 1'b0, mk(12'h000, 12'h000, 0, 2, 0, 0, 1, 0, 0, 0)};
  end

  initial begin
    prices[0] = 50; prices[1] = 50; prices[2] = 45;
    prices[3] = 100; prices[4] = 75; prices[5] = 30;
    load_prices();

    // Reset held across two edges
    tick(); tick();
    check("reset", actual(), mk(12'h000, 12'h000, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk50);
    reset_n = 1'b1;
    tick();

    // Table-driven vectors
    for (int i = 0; i < 16; i++) begin
      coin = vecs[i].coin; select_valid = vecs[i].sel; productSelect = vecs[i].idx;
      cancel = vecs[i].cncl; change_ready = vecs[i].rdy;
      tick();
      check($sformatf("vec%0d", i), actual(), vecs[i].exp);
      clear_strobes();
    end
    change_ready = 1'b0;

    // Cap boundary: 475 credit, 100 coin and invalid coin rejected
    for (int i = 0; i < 4; i++) put_coin(3'd4);
    for (int i = 0; i < 3; i++) put_coin(3'd3);
    put_coin(3'd4);
    check("cap_reject", actual(), mk(12'h475, 12'h000, 0, 2, 0, 0, 1, 0, 0, 0));
    put_coin(3'd6);
    check("invalid_reject", actual(), mk(12'h475, 12'h000, 0, 2, 0, 0, 1, 0, 0, 0));
    cancel = 1'b1; tick(); clear_strobes();
    check("cancel_475", actual(), mk(12'h000, 12'h475, 0, 2, 1, 1, 0, 0, 0, 1));
    change_ready = 1'b1;
    for (int i = 0; i < 100 && busy; i++) tick();
    change_ready = 1'b0;
    check("drain_475", actual(), mk(12'h000, 12'h000, 0, 2, 0, 0, 0, 0, 0, 0));

    // Coin and select together, exact price
    put_coin(3'd3); put_coin(3'd3);
    coin = 3'd3; select_valid = 1'b1; productSelect = 3'd1;
    tick(); clear_strobes();
    check("coin_sel_same", actual(), mk(12'h000, 12'h000, 1, 1, 0, 0, 1, 0, 0, 1));
    tick();
    check("zero_change", actual(), mk(12'h000, 12'h000, 0, 1, 0, 0, 0, 0, 0, 0));

    // 35c refund with stalled hopper
    put_coin(3'd3); put_coin(3'd2);
    cancel = 1'b1; tick(); clear_strobes();
    check("refund35", actual(), mk(12'h000, 12'h035, 0, 1, 1, 1, 0, 0, 0, 1));
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_hold", actual(), mk(12'h000, 12'h035, 0, 1, 1, 1, 0, 0, 0, 1));
    end
    change_ready = 1'b1;
    tick();
    check("refund_25_out", actual(), mk(12'h000, 12'h010, 0, 1, 1, 2, 0, 0, 0, 1));
    tick();
    check("refund_done", actual(), mk(12'h000, 12'h000, 0, 1, 0, 0, 0, 0, 0, 0));
    change_ready = 1'b0;

    // Inactivity behaviour
    put_coin(3'd2);
`ifdef VEND_TIMEOUT_EN
    for (int i = 0; i < TMO - 1; i++) tick();
    check("pre_timeout", actual(), mk(12'h010, 12'h000, 0, 1, 0, 0, 0, 0, 0, 0));
    tick();
    check("timeout_refund", actual(), mk(12'h000, 12'h010, 0, 1, 1, 2, 0, 0, 0, 1));
`else
    for (int i = 0; i < 150; i++) tick();
    check("credit_held", actual(), mk(12'h010, 12'h000, 0, 1, 0, 0, 0, 0, 0, 0));
    cancel = 1'b1; tick(); clear_strobes();
    check("cancel_10", actual(), mk(12'h000, 12'h010, 0, 1, 1, 2, 0, 0, 0, 1));
`endif

    // Asynchronous reset in CHANGE, checked before the next clock edge
    #3;
    reset_n = 1'b0;
    #1;
    check("async_reset", actual(), mk(12'h000, 12'h000, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk50);
    reset_n = 1'b1;

    // Randomised run against the reference model
    for (int k = 0; k < N; k++) prices[k] = 5 * $urandom_range(0, 40);
    load_prices();
    model_reset();
    @(negedge clk50);
    for (int i = 0; i < 3000; i++) begin
      coin          = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      select_valid  = ($urandom_range(0, 9) == 0);
      productSelect = 3'($urandom_range(0, 7));
      cancel        = ($urandom_range(0, 19) == 0);
      change_ready  = ($urandom_range(0, 1) == 1);
      model_step();
      tick();
      check("random", actual(), expected());
    end
    clear_strobes();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
